// File: rtl/evaluate_collect.sv
// ---------------------------------------------------------------------------
// evaluate_collect
//
// Consumer end of the evaluator output interface. Launched by the same
// board_valid / clear_eval pair that drives the per-feature evaluators, it
// captures each evaluator's signed mg/eg pair the first time its valid is
// seen, sums the captured pairs, tapers the sums by game phase and presents
// one saturated signed score with a held valid. Evaluators that do not
// respond within TIMEOUT_CYCLES collect cycles produce a zero score with
// eval_timeout set.
//
// Ports:
//   clk            clock
//   reset          synchronous active-high reset
//   board_valid    one-cycle pulse, new board presented to all evaluators
//   clear_eval     abort / acknowledge, returns the block to idle
//   phase          game phase, 0 = endgame, 256 = middlegame (>256 clamps)
//   eval_valid_in  per-evaluator valid level, held until clear_eval
//   eval_mg_in     packed signed mg scores, evaluator k at [k*EVAL_WIDTH +: EVAL_WIDTH]
//   eval_eg_in     packed signed eg scores, same packing
//   eval           signed tapered score
//   eval_valid     eval is stable; held until clear_eval
//   eval_timeout   raised with eval_valid when an evaluator missed the window
// ---------------------------------------------------------------------------
module evaluate_collect #(
    parameter int EVAL_WIDTH     = 24,
    parameter int NUM_EVALS      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            board_valid,
    input  logic                            clear_eval,
    input  logic [8:0]                      phase,
    input  logic [NUM_EVALS-1:0]            eval_valid_in,
    input  logic [NUM_EVALS*EVAL_WIDTH-1:0] eval_mg_in,
    input  logic [NUM_EVALS*EVAL_WIDTH-1:0] eval_eg_in,
    output logic [EVAL_WIDTH-1:0]           eval,
    output logic                            eval_valid,
    output logic                            eval_timeout
);

    // Sum width: one extra bit per doubling of evaluator count plus a guard bit.
    localparam int SUM_W   = EVAL_WIDTH + $clog2(NUM_EVALS) + 1;
    // Phase weights are 10-bit signed (0..256); one more bit for the sum of
    // the two products.
    localparam int PROD_W  = SUM_W + 11;
    localparam int SHIFT_W = PROD_W - 8;
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [SHIFT_W-1:0] SAT_MAX  =
        SHIFT_W'((longint'(1) << (EVAL_WIDTH - 1)) - 1);
    localparam logic signed [SHIFT_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SUM,
        TAPER,
        DONE
    } state_t;

    state_t                        state;
    logic [NUM_EVALS-1:0]          mask;
    logic [CNT_W-1:0]              cnt;
    logic [8:0]                    ph;
    logic signed [EVAL_WIDTH-1:0]  cap_mg [NUM_EVALS];
    logic signed [EVAL_WIDTH-1:0]  cap_eg [NUM_EVALS];
    logic signed [SUM_W-1:0]       mg_sum;
    logic signed [SUM_W-1:0]       eg_sum;

    logic [NUM_EVALS-1:0]          mask_next;
    logic [8:0]                    ph_clamped;
    logic signed [SUM_W-1:0]       mg_sum_c;
    logic signed [SUM_W-1:0]       eg_sum_c;
    logic signed [9:0]             ph_w;
    logic signed [9:0]             inv_w;
    logic signed [PROD_W-1:0]      t_full;
    logic signed [SHIFT_W-1:0]     t_shift;
    logic [EVAL_WIDTH-1:0]         taper_c;

    // Bits captured this cycle count toward completion immediately.
    assign mask_next  = mask | eval_valid_in;
    assign ph_clamped = (phase > 9'd256) ? 9'd256 : phase;

    always_comb begin
        mg_sum_c = '0;
        eg_sum_c = '0;
        for (int unsigned k = 0; k < NUM_EVALS; k++) begin
            mg_sum_c = mg_sum_c + SUM_W'(cap_mg[k]);
            eg_sum_c = eg_sum_c + SUM_W'(cap_eg[k]);
        end
    end

    always_comb begin
        ph_w    = $signed({1'b0, ph});
        inv_w   = $signed(10'd256 - {1'b0, ph});
        t_full  = PROD_W'(mg_sum) * PROD_W'(ph_w) + PROD_W'(eg_sum) * PROD_W'(inv_w);
        // Dropping the low 8 bits of a two's-complement value is an
        // arithmetic shift, i.e. floor toward minus infinity.
        t_shift = t_full[PROD_W-1:8];
        if (t_shift > SAT_MAX) begin
            taper_c = {1'b0, {(EVAL_WIDTH-1){1'b1}}};
        end else if (t_shift < SAT_MIN) begin
            taper_c = {1'b1, {(EVAL_WIDTH-1){1'b0}}};
        end else begin
            taper_c = t_shift[EVAL_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            eval         <= '0;
            eval_valid   <= 1'b0;
            eval_timeout <= 1'b0;
            mask         <= '0;
            cnt          <= '0;
            ph           <= '0;
            mg_sum       <= '0;
            eg_sum       <= '0;
            for (int unsigned k = 0; k < NUM_EVALS; k++) begin
                cap_mg[k] <= '0;
                cap_eg[k] <= '0;
            end
        end else if (clear_eval) begin
            // Abort from any state; eval keeps its value but is no longer valid.
            state        <= IDLE;
            eval_valid   <= 1'b0;
            eval_timeout <= 1'b0;
            mask         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (board_valid) begin
                        ph    <= ph_clamped;
                        mask  <= '0;
                        cnt   <= '0;
                        state <= COLLECT;
                    end
                end

                COLLECT: begin
                    for (int unsigned k = 0; k < NUM_EVALS; k++) begin
                        if (eval_valid_in[k] && !mask[k]) begin
                            cap_mg[k] <= eval_mg_in[k*EVAL_WIDTH +: EVAL_WIDTH];
                            cap_eg[k] <= eval_eg_in[k*EVAL_WIDTH +: EVAL_WIDTH];
                        end
                    end
                    mask <= mask_next;
                    cnt  <= cnt + 1'b1;
                    if (&mask_next) begin
                        state <= SUM;
                    end else if (cnt == CNT_LAST) begin
                        eval         <= '0;
                        eval_valid   <= 1'b1;
                        eval_timeout <= 1'b1;
                        state        <= DONE;
                    end
                end

                SUM: begin
                    mg_sum <= mg_sum_c;
                    eg_sum <= eg_sum_c;
                    state  <= TAPER;
                end

                TAPER: begin
                    eval         <= taper_c;
                    eval_valid   <= 1'b1;
                    eval_timeout <= 1'b0;
                    state        <= DONE;
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/evaluate_collect.md
Name: evaluate_collect

Overview:
- Consumer end of the evaluator output interface.
- Launches with the same board_valid/clear_eval pair that drives the per-feature evaluators (pawns, material, mobility, ...).
- Captures each evaluator's mg/eg pair when its eval_valid asserts, sums them, and tapers by game phase.
- Presents one signed score with its own held-valid to the search logic, and flags evaluators that fail to respond within a bounded window.

Parameters:
- EVAL_WIDTH, 24, width of signed mg/eg inputs and of the eval output.
- NUM_EVALS, 4, number of evaluator instances collected.
- TIMEOUT_CYCLES, 64, cycles allowed in COLLECT before giving up.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- board_valid  input  1  one-cycle pulse, new board presented to all evaluators
- clear_eval  input  1  abort/acknowledge; returns block to idle
- phase  input  9  game phase, 0 = pure endgame, 256 = pure middlegame; values >256 clamp to 256
- eval_valid_in  input  NUM_EVALS  per-evaluator valid, level, held until clear_eval
- eval_mg_in  input  NUM_EVALS*EVAL_WIDTH  packed signed mg scores, evaluator k at [k*EVAL_WIDTH+:EVAL_WIDTH]
- eval_eg_in  input  NUM_EVALS*EVAL_WIDTH  packed signed eg scores, same packing
- eval  output  EVAL_WIDTH  signed tapered score
- eval_valid  output  1  eval stable; held until clear_eval
- eval_timeout  output  1  set with eval_valid when any evaluator missed the window

Behaviour:
- Reset: state IDLE; eval=0, eval_valid=0, eval_timeout=0, capture mask=0, timeout counter=0.
- States: IDLE, COLLECT, SUM, TAPER, DONE.
- IDLE:
  - On board_valid, latch phase (clamped), clear mask and counter, go to COLLECT.
  - No capture occurs in the board_valid cycle.
- COLLECT:
  - For each k with eval_valid_in[k]=1 and mask[k]=0: capture mg/eg[k] and set mask[k].
  - Later changes on an already-captured input are ignored.
  - Counter increments every cycle.
  - Mask complete (including bits set this cycle) → SUM next cycle.
  - Else if counter == TIMEOUT_CYCLES-1 → DONE with eval=0, eval_timeout=1.
  - If completion and timeout occur in the same cycle, completion wins.
- SUM (1 cycle): mg_sum and eg_sum over captured values, computed at EVAL_WIDTH+$clog2(NUM_EVALS)+1 bits, sign-extended.
- TAPER (1 cycle):
  - t = mg_sum*phase + eg_sum*(256-phase), full-width signed.
  - Result = t >>> 8 (arithmetic, floor toward -inf).
  - Saturate to [-(2^(EVAL_WIDTH-1)), 2^(EVAL_WIDTH-1)-1].
  - Register into eval; go to DONE.
- DONE: eval_valid=1 and eval constant until clear_eval.
- Latency: if the last outstanding eval_valid_in is first sampled high in cycle c, eval_valid is high from cycle c+3.
- clear_eval (any state):
  - Next cycle: IDLE, eval_valid=0, eval_timeout=0, mask=0.
  - eval holds its last value but is not valid.
- clear_eval and board_valid in the same cycle: clear wins; board_valid is dropped.
- board_valid outside IDLE: ignored.
- Reset mid-operation: identical to the reset state; no partial result is ever presented.
- Captured values from an aborted board are never used; the mask is cleared on every launch.

Test Plan:
- Phase 256, mg={10,20,-5,7}, eg={99,99,99,99}, all valids 2 cycles after board_valid → eval=32, eval_timeout=0, eval_valid 3 cycles after the valids.
- Phase 0, eg={-40,-30,-20,-10}, mg arbitrary → eval=-100.
- Phase 128 rounding:
  - mg_sum=100, eg_sum=51 → eval=75.
  - mg_sum=-100, eg_sum=-51 → eval=-76.
  - phase=300 behaves as 256.
- Staggered valids at +2,+5,+9,+3 cycles after board_valid (cycle 0) → eval_valid first high at cycle 12 with the correct sum. Toggling eval_mg_in[0] after its capture does not change eval.
- Evaluator 3 never valid, TIMEOUT_CYCLES=64, board_valid at cycle 0 → eval_valid=1, eval_timeout=1, eval=0 at cycle 65. clear_eval then drops both flags next cycle.
- clear_eval at cycle 4 of COLLECT, new board_valid at cycle 6 with new values → result reflects only the new values.
- Simultaneous clear_eval+board_valid leaves the block in IDLE.
- mg all 2^23-1, phase 256 → eval saturates to 8388607.
